// File: rtl/decoder_host_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_host_pkg : shared modes, Trojan5 widths, pattern step     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package decoder_host_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ONEHOT     = 2'd0;
   localparam mode_t MODE_THERM      = 2'd1;
   localparam mode_t MODE_INV_ONEHOT = 2'd2;
   localparam mode_t MODE_RSVD       = 2'd3;

   localparam int TROJ_DAT_W = 14;
   localparam int TROJ_ADR_W = 13;
   localparam int PATTERN_W  = 128;

   // One shift of the pattern generator, taps 127 and 95 mixed with the code LSB
   function automatic logic [PATTERN_W-1:0] pattern_step(input logic [PATTERN_W-1:0] p,
                                                         input logic                 b);
      return {p[PATTERN_W-2:0], p[PATTERN_W-1] ^ p[95] ^ b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_cmd_fifo : synchronous command FIFO, registered level     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module decoder_cmd_fifo
   import decoder_host_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     pon_rst_n_i,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Full blocks a push even when a pop frees a slot in the same cycle
   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign wr_en    = push && !full;
   assign rd_en    = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge pon_rst_n_i) begin
      if (!pon_rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/trojan5.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Trojan5 : program-address scrambler fed by pattern and counter    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module Trojan5
   import decoder_host_pkg::*;
(
   input  logic                  pon_rst_n_i,
   input  logic [TROJ_DAT_W-1:0] prog_dat_i,
   input  logic [TROJ_ADR_W-1:0] pc_reg,
   output logic [TROJ_ADR_W-1:0] prog_adr_o
);

   logic [TROJ_ADR_W-1:0] scramble;

   assign scramble   = prog_dat_i[TROJ_ADR_W-1:0]
                     ^ {{(TROJ_ADR_W-1){1'b0}}, prog_dat_i[TROJ_DAT_W-1]};
   assign prog_adr_o = pon_rst_n_i ? (pc_reg ^ scramble) : '0;

endmodule
`default_nettype wire

// File: rtl/trojan5_stream_decoder_host.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trojan5_stream_decoder_host : FIFO-buffered streaming decoder     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module trojan5_stream_decoder_host
   import decoder_host_pkg::*;
#(
   parameter int                    DECODE_WIDTH   = 8,
   parameter int                    OUTPUT_COUNT   = 16,
   parameter int                    FIFO_DEPTH     = 4,
   parameter logic [PATTERN_W-1:0]  DECODE_PATTERN = 128'hFEDCBA9876543210FEDCBA9876543210
) (
   input  logic                          clk,
   input  logic                          pon_rst_n_i,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DECODE_WIDTH-1:0]       in_code,
   input  logic [1:0]                    in_mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUTPUT_COUNT-1:0]       out_data,
   output logic [1:0]                    out_mode,
   output logic                          out_error,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   decode_count
);

   localparam int CMD_W = DECODE_WIDTH + 2;

   logic [CMD_W-1:0]        head;
   logic [1:0]              head_mode;
   logic [DECODE_WIDTH-1:0] head_code;
   logic [OUTPUT_COUNT:0]   decoded;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push_fire;
   logic                    pop_fire;

   logic [PATTERN_W-1:0]    pattern_gen;
   logic [TROJ_ADR_W-1:0]   addr_cnt;
   logic [TROJ_DAT_W-1:0]   prog_dat_i;
   logic [TROJ_ADR_W-1:0]   pc_reg;
   logic [TROJ_ADR_W-1:0]   prog_adr_unused;

   // Result packed as {error, data}
   function automatic logic [OUTPUT_COUNT:0] decode_word(input logic [1:0]              mode,
                                                         input logic [DECODE_WIDTH-1:0] code);
      logic [OUTPUT_COUNT-1:0] onehot;
      logic [OUTPUT_COUNT-1:0] therm;
      logic [31:0]             c;
      logic                    in_range;
      c        = 32'(code);
      in_range = (c < 32'(OUTPUT_COUNT));
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         onehot[i] = (c == 32'(i));
         therm[i]  = (32'(i) <= c);
      end
      case (mode)
         MODE_ONEHOT:     return {!in_range, onehot};
         MODE_THERM:      return {!in_range, therm};
         MODE_INV_ONEHOT: return {!in_range, ~onehot};
         default:         return {1'b1, {OUTPUT_COUNT{1'b0}}};
      endcase
   endfunction

   assign in_ready  = !fifo_full;
   assign push_fire = in_valid && in_ready;
   assign pop_fire  = !fifo_empty && (!out_valid || out_ready);

   decoder_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk         (clk),
      .pon_rst_n_i (pon_rst_n_i),
      .push        (push_fire),
      .push_data   ({in_mode, in_code}),
      .pop         (pop_fire),
      .pop_data    (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .level       (fifo_level)
   );

   assign head_mode = head[CMD_W-1 -: 2];
   assign head_code = head[DECODE_WIDTH-1:0];
   assign decoded   = decode_word(head_mode, head_code);

   always_ff @(posedge clk or negedge pon_rst_n_i) begin
      if (!pon_rst_n_i) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_mode     <= '0;
         out_error    <= 1'b0;
         decode_count <= '0;
      end else begin
         if (pop_fire) begin
            out_valid <= 1'b1;
            out_data  <= decoded[OUTPUT_COUNT-1:0];
            out_error <= decoded[OUTPUT_COUNT];
            out_mode  <= head_mode;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) begin
            decode_count <= decode_count + 16'd1;
         end
      end
   end

   // The Trojan5 feed advances only on accepted input words
   always_ff @(posedge clk or negedge pon_rst_n_i) begin
      if (!pon_rst_n_i) begin
         pattern_gen <= DECODE_PATTERN;
         addr_cnt    <= '0;
      end else if (push_fire) begin
         pattern_gen <= pattern_step(pattern_gen, in_code[0]);
         addr_cnt    <= addr_cnt + TROJ_ADR_W'(1);
      end
   end

   assign prog_dat_i = pattern_gen[TROJ_DAT_W-1:0];
   assign pc_reg     = addr_cnt;

   Trojan5 trojan_inst (
      .pon_rst_n_i (pon_rst_n_i),
      .prog_dat_i  (prog_dat_i),
      .pc_reg      (pc_reg),
      .prog_adr_o  (prog_adr_unused)
   );

endmodule
`default_nettype wire

// File: tb/tb_trojan5_stream_decoder_host.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_trojan5_stream_decoder_host : directed bench with queue model  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_trojan5_stream_decoder_host;

   localparam logic [127:0] PAT = 128'hFEDCBA9876543210FEDCBA9876543210;

   logic        clk = 1'b0;
   logic        pon_rst_n_i = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_code = 8'd0;
   logic [1:0]  in_mode = 2'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [1:0]  out_mode;
   logic        out_error;
   logic [2:0]  fifo_level;
   logic [15:0] decode_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trojan5_stream_decoder_host dut (
      .clk          (clk),
      .pon_rst_n_i  (pon_rst_n_i),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .in_mode      (in_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_mode     (out_mode),
      .out_error    (out_error),
      .fifo_level   (fifo_level),
      .decode_count (decode_count)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected {mode, error, data} straight from the decode rules
   function automatic logic [18:0] model_dec(input logic [1:0] m, input logic [7:0] c);
      int          ci;
      logic [15:0] d;
      logic        e;
      ci = int'(c);
      e  = (ci >= 16);
      case (m)
         2'd0: d = (ci < 16) ? 16'(32'd1 << ci) : 16'h0000;
         2'd1: d = (ci < 16) ? 16'((32'd1 << (ci + 1)) - 32'd1) : 16'hFFFF;
         2'd2: d = (ci < 16) ? ~16'(32'd1 << ci) : 16'hFFFF;
         default: begin d = 16'h0000; e = 1'b1; end
      endcase
      return {m, e, d};
   endfunction

   logic [18:0]  exp_q[$];
   int unsigned  m_count = 0;
   logic [127:0] m_pat   = PAT;
   logic [12:0]  m_addr  = 13'd0;

   always @(negedge clk) begin
      if (!pon_rst_n_i) begin
         exp_q.delete();
         m_count = 0;
         m_pat   = PAT;
         m_addr  = 13'd0;
      end else begin
         chk("decode_count", 128'(decode_count), 128'(16'(m_count)));
         chk("pattern_gen", dut.pattern_gen, m_pat);
         chk("pc_reg", 128'(dut.pc_reg), 128'(m_addr));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 128'(out_valid), 128'(1'b0));
            end else begin
               chk("out_data", 128'(out_data), 128'(exp_q[0][15:0]));
               chk("out_error", 128'(out_error), 128'(exp_q[0][16]));
               chk("out_mode", 128'(out_mode), 128'(exp_q[0][18:17]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  m_count++;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_dec(in_mode, in_code));
            m_pat  = {m_pat[126:0], m_pat[127] ^ m_pat[95] ^ in_code[0]};
            m_addr = m_addr + 13'd1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] m, input logic [7:0] c);
      int n = 0;
      in_valid = 1'b1;
      in_mode  = m;
      in_code  = c;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1'b1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out;
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) chk("wait_out_timeout", 128'(out_valid), 128'(1'b1));
   endtask

   logic [1:0]  t2_mode [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
   logic [7:0]  t2_code [4] = '{8'd5, 8'd0, 8'd20, 8'd2};
   logic [15:0] t2_data [4] = '{16'h003F, 16'hFFFE, 16'h0000, 16'h0000};
   logic        t2_err  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      tick();
      tick();
      chk("rst_level", 128'(fifo_level), 128'(3'd0));
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_count", 128'(decode_count), 128'(16'd0));
      pon_rst_n_i = 1'b1;
      out_ready   = 1'b1;
      tick();

      // Word presented after edge N: stored at N+1, result visible after N+2
      send(2'd0, 8'd3);
      chk("t1_no_bypass", 128'(out_valid), 128'(1'b0));
      tick();
      chk("t1_valid", 128'(out_valid), 128'(1'b1));
      chk("t1_data", 128'(out_data), 128'(16'h0008));
      chk("t1_err", 128'(out_error), 128'(1'b0));
      tick();
      chk("t1_count", 128'(decode_count), 128'(16'd1));
      chk("t1_drained", 128'(out_valid), 128'(1'b0));

      for (int k = 0; k < 4; k++) begin
         send(t2_mode[k], t2_code[k]);
         wait_out();
         chk("t2_data", 128'(out_data), 128'(t2_data[k]));
         chk("t2_err", 128'(out_error), 128'(t2_err[k]));
         chk("t2_mode", 128'(out_mode), 128'(t2_mode[k]));
         tick();
      end
      chk("t2_count", 128'(decode_count), 128'(16'd5));

      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send(2'd0, 8'(k));
      chk("t3_level", 128'(fifo_level), 128'(3'd4));
      chk("t3_in_ready", 128'(in_ready), 128'(1'b0));
      chk("t3_head", 128'(out_data), 128'(16'h0002));

      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t4_hold", 128'(out_data), 128'(16'h0002));
      end
      chk("t4_count_held", 128'(decode_count), 128'(16'd5));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_pulse_count", 128'(decode_count), 128'(16'd6));
      chk("t4_next", 128'(out_data), 128'(16'h0004));
      chk("t4_level", 128'(fifo_level), 128'(3'd3));
      tick();
      chk("t4_single", 128'(decode_count), 128'(16'd6));
      out_ready = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk("t3_stream_valid", 128'(out_valid), 128'(1'b1));
         chk("t3_stream_data", 128'(out_data), 128'(16'(32'd1 << k)));
      end
      tick();
      chk("t3_drained", 128'(out_valid), 128'(1'b0));
      chk("t3_count", 128'(decode_count), 128'(16'd10));
      chk("t3_level0", 128'(fifo_level), 128'(3'd0));

      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send(2'd1, 8'(k));
      chk("t6_level3", 128'(fifo_level), 128'(3'd3));
      #2 pon_rst_n_i = 1'b0;
      #1;
      chk("t6_out_valid", 128'(out_valid), 128'(1'b0));
      chk("t6_level", 128'(fifo_level), 128'(3'd0));
      chk("t6_in_ready", 128'(in_ready), 128'(1'b1));
      chk("t6_data", 128'(out_data), 128'(16'h0000));
      chk("t6_mode", 128'(out_mode), 128'(2'd0));
      chk("t6_count", 128'(decode_count), 128'(16'd0));
      chk("t6_pc", 128'(dut.pc_reg), 128'(13'd0));
      tick();
      tick();
      pon_rst_n_i = 1'b1;
      out_ready   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t6_no_stale", 128'(out_valid), 128'(1'b0));
         chk("t6_level_post", 128'(fifo_level), 128'(3'd0));
      end

      for (int i = 0; i < 8192; i++) begin
         send(2'(i), 8'(i * 7));
         if (i == 0) chk("t5_pat_first", dut.pattern_gen, 128'hFDB97530ECA86421FDB97530ECA86421);
         if (i == 8190) chk("t5_pc_max", 128'(dut.pc_reg), 128'(13'h1FFF));
         if (i % 1000 == 999) tick();
      end
      chk("t5_pc_wrap", 128'(dut.pc_reg), 128'(13'h0000));
      tick();
      tick();
      tick();
      chk("t5_drained", 128'(out_valid), 128'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
